// File: rtl/simplerisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simplerisc_pkg
// Purpose  : Shared SimpleRisc constants for the execute-stage branch logic:
//            opcode encodings, the NOP encoding used for bubbles, instruction
//            field positions and the wrong-path squash depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package simplerisc_pkg;

  typedef logic [4:0] opcode_t;

  // Instruction field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OFF_MSB = 26;
  localparam int OFF_LSB = 0;
  localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

  // Opcode encodings
  localparam opcode_t OP_BEQ  = 5'b10000;
  localparam opcode_t OP_BGT  = 5'b10001;
  localparam opcode_t OP_B    = 5'b10010;
  localparam opcode_t OP_CALL = 5'b10011;
  localparam opcode_t OP_RET  = 5'b10100;
  localparam opcode_t OP_CMP  = 5'b00101;
  localparam opcode_t OP_NOP  = 5'b01101;

  // Bubble inserted on reset and on squash
  localparam logic [31:0] NOP_INSN = 32'h6800_0000;

  // Fetch has one register stage, so two wrong-path instructions are in
  // flight when a taken branch resolves in E.
  localparam int SQUASH_DEPTH = 2;
  localparam int SQUASH_CNT_W = (SQUASH_DEPTH > 2) ? $clog2(SQUASH_DEPTH) : 1;

  function automatic opcode_t opcode_of(input logic [31:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

endpackage : simplerisc_pkg
`default_nettype wire

// File: rtl/branch_execute_cycle_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_execute_cycle_if
// Purpose  : Bundles the decode-side inputs, operand inputs and the
//            redirect / flags / call-writeback outputs of the execute-stage
//            branch unit.
// Modports : master - upstream/environment side (drives D-stage and operands)
//            slave  - branch_execute_cycle side
// Revision : 1.0 - initial release
// ============================================================================
interface branch_execute_cycle_if;

  logic [31:0] instruction_D;
  logic [31:0] pc_D;
  logic [31:0] op1_E;
  logic [31:0] op2_E;
  logic [31:0] ra_E;

  logic [31:0] instruction_E;
  logic [31:0] pc_E;
  logic        isbranchtaken_E;
  logic [31:0] pc_branch_E;
  logic        flag_eq;
  logic        flag_gt;
  logic        call_wen_E;
  logic [31:0] call_wdata_E;
  logic        squash_active;

  modport master (
    output instruction_D, pc_D, op1_E, op2_E, ra_E,
    input  instruction_E, pc_E, isbranchtaken_E, pc_branch_E,
           flag_eq, flag_gt, call_wen_E, call_wdata_E, squash_active
  );

  modport slave (
    input  instruction_D, pc_D, op1_E, op2_E, ra_E,
    output instruction_E, pc_E, isbranchtaken_E, pc_branch_E,
           flag_eq, flag_gt, call_wen_E, call_wdata_E, squash_active
  );

endinterface : branch_execute_cycle_if
`default_nettype wire

// File: rtl/branch_execute_cycle_branch_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_calc
// Purpose  : Combinational branch resolution for the instruction in E.
// Ports    : en       - resolution enabled (no squash in progress)
//            opcode   - opcode of instruction_E
//            pc       - pc_E
//            offset   - signed word offset field of instruction_E
//            ra       - current r15 value (ret target)
//            flag_eq  - flags.E
//            flag_gt  - flags.GT
//            taken    - redirect fetch
//            target   - redirect address (0 when not taken)
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_calc
  import simplerisc_pkg::*;
(
  input  logic             en,
  input  opcode_t          opcode,
  input  logic [31:0]      pc,
  input  logic [OFF_W-1:0] offset,
  input  logic [31:0]      ra,
  input  logic             flag_eq,
  input  logic             flag_gt,
  output logic             taken,
  output logic [31:0]      target
);

  logic [31:0] w_target_rel;

  // Word offset -> byte offset, sign-extended; sum wraps mod 2^32.
  assign w_target_rel = pc + {{(32 - OFF_W - 2){offset[OFF_W-1]}}, offset, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = 32'h0;
    if (en) begin
      case (opcode)
        OP_B, OP_CALL: begin
          taken  = 1'b1;
          target = w_target_rel;
        end
        OP_BEQ: begin
          taken  = flag_eq;
          target = flag_eq ? w_target_rel : 32'h0;
        end
        OP_BGT: begin
          taken  = flag_gt;
          target = flag_gt ? w_target_rel : 32'h0;
        end
        OP_RET: begin
          taken  = 1'b1;
          target = ra;
        end
        default: begin
          taken  = 1'b0;
          target = 32'h0;
        end
      endcase
    end
  end

endmodule : branch_target_calc
`default_nettype wire

// File: rtl/branch_execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : branch_execute_cycle
// Purpose  : SimpleRisc execute-stage branch unit. Holds the D->E pipeline
//            register and the cmp flags, resolves b/beq/bgt/call/ret and
//            squashes the two wrong-path instructions behind a taken branch.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - branch_execute_cycle_if.slave
//                   in : instruction_D, pc_D, op1_E, op2_E, ra_E
//                   out: instruction_E, pc_E, isbranchtaken_E, pc_branch_E,
//                        flag_eq, flag_gt, call_wen_E, call_wdata_E,
//                        squash_active
// Revision : 1.0 - initial release
// ============================================================================
module branch_execute_cycle
  import simplerisc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  branch_execute_cycle_if.slave  bus
);

  localparam logic [SQUASH_CNT_W-1:0] SQUASH_RELOAD = SQUASH_CNT_W'(SQUASH_DEPTH - 1);

  logic [31:0]             r_instruction_E;
  logic [31:0]             r_pc_E;
  logic                    r_flag_eq;
  logic                    r_flag_gt;
  logic [SQUASH_CNT_W-1:0] r_squash_cnt;

  logic                    w_idle;
  opcode_t                 w_opcode;
  logic                    w_taken;
  logic [31:0]             w_target;

  assign w_idle   = (r_squash_cnt == '0);
  assign w_opcode = opcode_of(r_instruction_E);

  branch_target_calc u_target (
    .en      (w_idle),
    .opcode  (w_opcode),
    .pc      (r_pc_E),
    .offset  (r_instruction_E[OFF_MSB:OFF_LSB]),
    .ra      (bus.ra_E),
    .flag_eq (r_flag_eq),
    .flag_gt (r_flag_gt),
    .taken   (w_taken),
    .target  (w_target)
  );

  // D->E slot and squash counter. A taken branch loads the counter with
  // depth-1 because the edge that sees the branch already kills the first
  // wrong-path instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instruction_E <= NOP_INSN;
      r_pc_E          <= 32'h0;
      r_squash_cnt    <= '0;
    end else if (w_taken) begin
      r_instruction_E <= NOP_INSN;
      r_pc_E          <= 32'h0;
      r_squash_cnt    <= SQUASH_RELOAD;
    end else if (!w_idle) begin
      r_instruction_E <= NOP_INSN;
      r_pc_E          <= 32'h0;
      r_squash_cnt    <= r_squash_cnt - SQUASH_CNT_W'(1);
    end else begin
      r_instruction_E <= bus.instruction_D;
      r_pc_E          <= bus.pc_D;
    end
  end

  // Flags: a cmp in E updates them at its edge, so a following beq/bgt
  // sees the new values with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_eq <= 1'b0;
      r_flag_gt <= 1'b0;
    end else if (w_idle && (w_opcode == OP_CMP)) begin
      r_flag_eq <= (bus.op1_E == bus.op2_E);
      r_flag_gt <= ($signed(bus.op1_E) > $signed(bus.op2_E));
    end
  end

  assign bus.instruction_E   = r_instruction_E;
  assign bus.pc_E            = r_pc_E;
  assign bus.isbranchtaken_E = w_taken;
  assign bus.pc_branch_E     = w_target;
  assign bus.flag_eq         = r_flag_eq;
  assign bus.flag_gt         = r_flag_gt;
  assign bus.call_wen_E      = w_idle && (w_opcode == OP_CALL);
  assign bus.call_wdata_E    = r_pc_E + 32'd4;
  assign bus.squash_active   = !w_idle;

endmodule : branch_execute_cycle
`default_nettype wire

// File: doc/branch_execute_cycle.md
Name: branch_execute_cycle

Overview:
- Execute-stage consumer of the fetch stage's decode-side outputs (instruction_D, pc_D); drives the branch redirect pair (isbranchtaken_E, pc_branch_E) back into fetch.
- Registers the D->E pipeline slot and holds the cmp flags register.
- Resolves b/beq/bgt/call/ret and squashes the two wrong-path instructions already in flight after a taken branch.
- Sits between the decode/register-read logic and the ALU/writeback path of the SimpleRisc 5-stage pipeline.

Parameters:
NOP_INSN, 32'h6800_0000, encoding inserted on reset and on squash (opcode 01101)
SQUASH_DEPTH, 2, wrong-path instructions killed after a taken branch (fixed by fetch's single register stage)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
instruction_D  in  32  instruction from fetch pipeline register
pc_D  in  32  PC of instruction_D
op1_E  in  32  resolved rs1 operand for instruction_E (from regfile/forwarding)
op2_E  in  32  resolved second operand for instruction_E (register or sign-extended immediate, selected upstream)
ra_E  in  32  current r15 value, used by ret
instruction_E  out  32  E-stage instruction register
pc_E  out  32  E-stage PC register
isbranchtaken_E  out  1  redirect fetch this cycle (combinational from E state)
pc_branch_E  out  32  redirect target (combinational)
flag_eq  out  1  flags.E register
flag_gt  out  1  flags.GT register
call_wen_E  out  1  write r15 this cycle (call in E)
call_wdata_E  out  32  pc_E + 4
squash_active  out  1  squash counter non-zero

Behaviour:
- Reset (rst=1 at edge): instruction_E<=NOP_INSN, pc_E<=0, flag_eq<=0, flag_gt<=0, squash_cnt<=0. Reset dominates all other events. With instruction_E=NOP: isbranchtaken_E=0, pc_branch_E=0, call_wen_E=0.
- Decode of instruction_E: opcode=[31:27]. beq=10000, bgt=10001, b=10010, call=10011, ret=10100, cmp=00101, nop=01101.
- Branch offset:
  - offset=instruction_E[26:0], signed.
  - target_rel = pc_E + sext32({offset,2'b00}); arithmetic mod 2^32 (wrap allowed, no error).
- Taken decision, combinational, gated by squash_cnt==0:
  - b, call: always taken.
  - beq: taken iff flag_eq.
  - bgt: taken iff flag_gt.
  - ret: taken, target = ra_E.
  - All other opcodes: not taken, pc_branch_E=0.
- pc_branch_E = target_rel for b/beq/bgt/call, ra_E for ret, 0 otherwise. Not-taken beq/bgt drive pc_branch_E=0.
- call_wen_E=1 for call in E (squash_cnt==0); call_wdata_E=pc_E+4 always.
- Flags: at edge, if instruction_E is cmp and squash_cnt==0:
  - flag_eq<=(op1_E==op2_E)
  - flag_gt<=($signed(op1_E)>$signed(op2_E))
  - Otherwise flags hold. A beq/bgt in the cycle immediately after a cmp sees the updated flags (0-cycle bubble).
- D->E register, priority rst > squash > load:
  - If isbranchtaken_E=1 at edge: instruction_E<=NOP_INSN, pc_E<=0, squash_cnt<=SQUASH_DEPTH-1.
  - Else if squash_cnt!=0: instruction_E<=NOP_INSN, pc_E<=0, squash_cnt<=squash_cnt-1.
  - Else: instruction_E<=instruction_D, pc_E<=pc_D.
- Squash timing: taken branch in E at cycle t. The instructions captured at edges t+1 and t+2 are replaced by NOP. The instruction_D sampled at edge t+3 is the branch target instruction.
- A branch arriving in instruction_D during squash is discarded (wrong path); squashed cmp never updates flags.
- squash_active = (squash_cnt!=0).

Decomposition:
- Shared package simplerisc_pkg: opcode localparams (OP_BEQ, OP_BGT, OP_B, OP_CALL, OP_RET, OP_CMP, OP_NOP), NOP_INSN constant, field position constants.
- One sub-module: branch_target_calc (combinational; opcode, pc_E, offset, ra_E, flags -> taken, target).
- Flags register, squash counter and E register stay in the top.

Test Plan:
- Reset: hold rst 2 cycles with instruction_D=32'h9000_0004 -> instruction_E=32'h6800_0000, pc_E=0, isbranchtaken_E=0, flags 0.
- Unconditional b: pc_D=0x100, instruction_D=b offset +4 (32'h9000_0004) -> next cycle isbranchtaken_E=1, pc_branch_E=0x110. The next two E loads are NOP with squash_active=1. The third loads instruction_D.
- Backward wrap: pc_D=0x0, b offset 27'h7FF_FFFF (-1) -> pc_branch_E=0xFFFF_FFFC.
- cmp then beq:
  - cmp with op1_E=op2_E=5 -> flag_eq=1, flag_gt=0.
  - Following beq +2 at pc 0x20 -> taken, target 0x28.
  - Repeat with op1_E=7, op2_E=-3 -> beq not taken, bgt taken.
- call/ret: call at pc 0x40 -> call_wen_E=1, call_wdata_E=0x44. Later ret with ra_E=0x44 -> isbranchtaken_E=1, pc_branch_E=0x44.
- Squash interactions:
  - cmp arriving in the squash window -> flags unchanged.
  - rst asserted while squash_cnt=1 -> squash_cnt=0 and NOP next cycle.
